// File: rtl/razor_error_ctrl.sv
// Razor timing-error receiver: turns per-stage error flags into a restore/stall
// recovery sequence and nudges the operating level from the windowed error rate.
module razor_error_ctrl #(
  parameter int N_ERR      = 8,
  parameter int REPLAY_CYC = 2,
  parameter int WIN_LEN    = 1024,
  parameter int HI_TH      = 4,
  parameter int LO_TH      = 0,
  parameter int VW         = 4,
  parameter int V_INIT     = 8,
  parameter int V_MIN      = 0,
  parameter int V_MAX      = 15
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Enable,
  input  logic [N_ERR-1:0] Error_in,
  output logic             Stall,
  output logic             Restore,
  output logic [VW-1:0]    Vlevel,
  output logic             Vchange,
  output logic [15:0]      Err_total,
  output logic [7:0]       Win_err
);

  localparam int              WCW       = $clog2(WIN_LEN);
  localparam logic [WCW-1:0]  WIN_LAST  = WCW'(WIN_LEN - 1);
  localparam logic [3:0]      REPLAY_LD = 4'(REPLAY_CYC - 1);
  localparam logic [7:0]      HI_TH_C   = 8'(HI_TH);
  localparam logic [7:0]      LO_TH_C   = 8'(LO_TH);
  localparam logic [VW-1:0]   VMIN_C    = VW'(V_MIN);
  localparam logic [VW-1:0]   VMAX_C    = VW'(V_MAX);
  localparam logic [VW-1:0]   VINIT_C   = VW'(V_INIT);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t         state, state_nxt;
  logic [3:0]     stall_cnt, stall_cnt_nxt;
  logic           stall_nxt, restore_nxt;
  logic           err_ev, win_end;
  logic [WCW-1:0] win_cnt;
  logic [VW-1:0]  vlevel_nxt;
  logic           vchange_nxt;
  logic [7:0]     win_err_nxt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Flags are only looked at in RUN, which masks them during and at the end of a stall.
  assign err_ev  = (state == RUN) && (|Error_in);
  assign win_end = Enable && (win_cnt == WIN_LAST);

  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = stall_cnt;
    stall_nxt     = Stall;
    restore_nxt   = 1'b0;
    case (state)
      RUN: begin
        if (err_ev) begin
          state_nxt     = RECOVER;
          stall_nxt     = 1'b1;
          restore_nxt   = 1'b1;
          stall_cnt_nxt = REPLAY_LD;
        end
      end
      RECOVER: begin
        if (stall_cnt == 4'd0) begin
          state_nxt = RUN;
          stall_nxt = 1'b0;
        end else begin
          stall_cnt_nxt = stall_cnt - 4'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Level decision uses the window count before any same-cycle error event.
  always_comb begin
    vlevel_nxt  = Vlevel;
    vchange_nxt = 1'b0;
    win_err_nxt = err_ev ? sat_inc8(Win_err) : Win_err;
    if (win_end) begin
      win_err_nxt = err_ev ? 8'd1 : 8'd0;
      if (Win_err >= HI_TH_C && Vlevel < VMAX_C) begin
        vlevel_nxt  = Vlevel + VW'(1);
        vchange_nxt = 1'b1;
      end else if (Win_err <= LO_TH_C && Vlevel > VMIN_C) begin
        vlevel_nxt  = Vlevel - VW'(1);
        vchange_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= RUN;
      stall_cnt <= 4'd0;
      Stall     <= 1'b0;
      Restore   <= 1'b0;
      Vlevel    <= VINIT_C;
      Vchange   <= 1'b0;
      Err_total <= 16'd0;
      Win_err   <= 8'd0;
      win_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      Stall     <= stall_nxt;
      Restore   <= restore_nxt;
      Vlevel    <= vlevel_nxt;
      Vchange   <= vchange_nxt;
      Win_err   <= win_err_nxt;
      if (err_ev)
        Err_total <= sat_inc16(Err_total);
      if (Enable)
        win_cnt <= win_end ? '0 : win_cnt + WCW'(1);
    end
  end

endmodule

// File: tb/tb_razor_error_ctrl.sv
// Scoreboard bench for razor_error_ctrl: stimulus queues expected Restore, Stall,
// Vchange and state snapshots; a negedge monitor matches them against the DUT.
module tb_razor_error_ctrl;

  localparam int RC = 2;

  logic        Clock = 1'b0;
  logic        nReset;
  logic        Enable;
  logic [7:0]  Error_in;
  logic        Stall, Restore, Vchange;
  logic [3:0]  Vlevel;
  logic [15:0] Err_total;
  logic [7:0]  Win_err;

  razor_error_ctrl #(
    .N_ERR(8), .REPLAY_CYC(RC), .WIN_LEN(16), .HI_TH(4), .LO_TH(0),
    .VW(4), .V_INIT(8), .V_MIN(0), .V_MAX(15)
  ) dut (
    .Clock(Clock), .nReset(nReset), .Enable(Enable), .Error_in(Error_in),
    .Stall(Stall), .Restore(Restore), .Vlevel(Vlevel), .Vchange(Vchange),
    .Err_total(Err_total), .Win_err(Win_err)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct { int cyc; int total; } rst_t;
  typedef struct { int cyc; int lvl; } vc_t;
  typedef struct { int cyc; logic st; logic rs; logic vc; int lvl; int tot; int win; } snap_t;

  rst_t  restore_q[$];
  vc_t   vchange_q[$];
  snap_t snap_q[$];
  int    stall_q[$];

  int cur_lvl   = 8;
  int exp_total = 0;
  bit done      = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int stall_run = 0;
  rst_t  r_e;
  vc_t   v_e;
  snap_t s_e;
  int    st_e;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic push_snap(input logic st, input logic rs, input logic vc,
                           input int lvl, input int tot, input int win);
    snap_t s;
    s.cyc = cyc; s.st = st; s.rs = rs; s.vc = vc;
    s.lvl = lvl; s.tot = tot; s.win = win;
    snap_q.push_back(s);
  endtask

  // Error_in is applied now and sampled at the next edge: Restore follows one cycle later.
  task automatic exp_restore(input int stall_len);
    rst_t r;
    exp_total++;
    r.cyc = cyc + 1;
    r.total = exp_total;
    restore_q.push_back(r);
    stall_q.push_back(stall_len);
  endtask

  // One aligned 16-cycle window; errors at offsets 0,4,8,12 and optionally on the last edge.
  task automatic run_window(input int nerr, input int pause_at, input bit late, input int exp_lvl);
    vc_t v;
    bit  err;
    Enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == pause_at) begin
        Enable = 1'b0;
        Error_in = 8'h00;
        tick(100);
        Enable = 1'b1;
      end
      err = ((i % 4 == 0) && (i / 4 < nerr)) || (late && i == 15);
      Error_in = err ? (8'h01 << (i / 2)) : 8'h00;
      if (err) exp_restore(RC);
      tick(1);
    end
    Error_in = 8'h00;
    if (exp_lvl != cur_lvl) begin
      v.cyc = cyc;
      v.lvl = exp_lvl;
      vchange_q.push_back(v);
    end
    push_snap(late, late, (exp_lvl != cur_lvl), exp_lvl, exp_total, late ? 1 : 0);
    cur_lvl = exp_lvl;
  endtask

  initial begin
    nReset = 1'b0; Enable = 1'b0; Error_in = 8'h00;
    tick(2);
    push_snap(0, 0, 0, 8, 0, 0);
    tick(1);
    nReset = 1'b1;
    push_snap(0, 0, 0, 8, 0, 0);
    tick(50);
    push_snap(0, 0, 0, 8, 0, 0);

    // Single flag, bit 3, with Enable low: still serviced.
    Error_in = 8'h08;
    exp_restore(RC);
    tick(1);
    Error_in = 8'h00;
    tick(4);
    push_snap(0, 0, 0, 8, 1, 1);

    // Held 0xFF for six cycles: accepted at offsets 0 and 3 only.
    for (int i = 0; i < 6; i++) begin
      Error_in = 8'hFF;
      if (i == 3) push_snap(0, 0, 0, 8, 2, 2);
      if (i == 0 || i == 3) exp_restore(RC);
      tick(1);
    end
    Error_in = 8'h00;
    tick(3);
    push_snap(0, 0, 0, 8, 3, 3);

    run_window(0, -1, 0, 8);
    run_window(4, -1, 0, 9);
    run_window(0, -1, 0, 8);
    for (int l = 9; l <= 15; l++) run_window(4, -1, 0, l);
    run_window(4, -1, 0, 15);
    for (int l = 14; l >= 0; l--) run_window(0, -1, 0, l);
    run_window(0, -1, 0, 0);
    run_window(4, 6, 0, 1);
    run_window(3, -1, 1, 1);
    run_window(0, -1, 0, 1);

    // Reset in the second stall cycle: everything drops without a clock edge.
    Error_in = 8'h01;
    exp_restore(1);
    tick(1);
    Error_in = 8'h00;
    tick(1);
    nReset = 1'b0;
    exp_total = 0;
    cur_lvl = 8;
    push_snap(0, 0, 0, 8, 0, 0);
    tick(2);
    nReset = 1'b1;
    push_snap(0, 0, 0, 8, 0, 0);
    tick(3);
    done = 1'b1;
  end

  initial begin
    while (!done) begin
      @(negedge Clock);
      if (Restore === 1'b1) begin
        chk("restore_with_stall", Stall, 1);
        if (restore_q.size() == 0) chk("restore_unexpected", 1, 0);
        else begin
          r_e = restore_q.pop_front();
          chk("restore_cycle", cyc, r_e.cyc);
          chk("restore_err_total", Err_total, r_e.total);
        end
      end
      if (Vchange === 1'b1) begin
        if (vchange_q.size() == 0) chk("vchange_unexpected", 1, 0);
        else begin
          v_e = vchange_q.pop_front();
          chk("vchange_cycle", cyc, v_e.cyc);
          chk("vchange_level", Vlevel, v_e.lvl);
        end
      end
      if (Stall === 1'b1) stall_run++;
      else if (stall_run > 0) begin
        if (stall_q.size() == 0) chk("stall_unexpected", stall_run, 0);
        else begin
          st_e = stall_q.pop_front();
          chk("stall_length", stall_run, st_e);
        end
        stall_run = 0;
      end
      while (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
        s_e = snap_q.pop_front();
        chk("snap_stall", Stall, s_e.st);
        chk("snap_restore", Restore, s_e.rs);
        chk("snap_vchange", Vchange, s_e.vc);
        chk("snap_vlevel", Vlevel, s_e.lvl);
        chk("snap_err_total", Err_total, s_e.tot);
        chk("snap_win_err", Win_err, s_e.win);
      end
    end
    chk("restore_q_left", restore_q.size(), 0);
    chk("vchange_q_left", vchange_q.size(), 0);
    chk("stall_q_left", stall_q.size(), 0);
    chk("snap_q_left", snap_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got time %0t expected finish before 100000", $time);
    $fatal(1);
  end

endmodule
